// File: rtl/tail_light_monitor.sv
// ---------------------------------------------------------------------------
// tail_light_monitor
//
// Receive-side checker for the six-lamp turn-signal bus {LC,LB,LA,RA,RB,RC}.
// Follows the lamp vector every clock against the legal left, right and
// hazard step sequences. It pulses a done flag for each completed sequence
// and flags protocol violations. It also keeps saturating event counters.
//
// Parameters:
//   CNT_W    - width of each event counter (saturates at 2**CNT_W-1)
//   MAX_HOLD - extra consecutive cycles a step pattern may repeat
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   LC,LB,LA,RA,RB,RC   - sampled lamp inputs (already synchronous to clk)
//   left_done           - one-cycle pulse, left sequence completed
//   right_done          - one-cycle pulse, right sequence completed
//   hazard_done         - one-cycle pulse, hazard sequence completed
//   err                 - violation flag (pulse, or sticky with the macro)
//   mon_state           - current monitor state code
//   left_cnt, right_cnt, hazard_cnt, err_cnt - saturating event counters
//
// Build option:
//   STICKY_ERR_EN - when defined, err latches on the first violation and
//                   stays high until reset. When undefined, err pulses once
//                   per violation event.
// ---------------------------------------------------------------------------
module tail_light_monitor #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LC,
  input  logic             LB,
  input  logic             LA,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  output logic             left_done,
  output logic             right_done,
  output logic             hazard_done,
  output logic             err,
  output logic [3:0]       mon_state,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_L1     = 4'd1,
    S_L2     = 4'd2,
    S_L3     = 4'd3,
    S_R1     = 4'd4,
    S_R2     = 4'd5,
    S_R3     = 4'd6,
    S_H1     = 4'd7,
    S_H2     = 4'd8,
    S_H3     = 4'd9,
    S_RESYNC = 4'd10
  } state_t;

  localparam logic [5:0] PAT_OFF = 6'b000000;
  localparam logic [5:0] PAT_L1  = 6'b001000;
  localparam logic [5:0] PAT_L2  = 6'b011000;
  localparam logic [5:0] PAT_L3  = 6'b111000;
  localparam logic [5:0] PAT_R1  = 6'b000100;
  localparam logic [5:0] PAT_R2  = 6'b000110;
  localparam logic [5:0] PAT_R3  = 6'b000111;
  localparam logic [5:0] PAT_H1  = 6'b001100;
  localparam logic [5:0] PAT_H2  = 6'b011110;
  localparam logic [5:0] PAT_H3  = 6'b111111;

  // The hold counter needs at least one bit, even when no hold is allowed.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [5:0]        lamp;
  logic [5:0]        cur_pat;
  logic [5:0]        adv_pat;
  state_t            adv_state;
  logic [1:0]        seq_id;
  logic              in_step;
  logic              hold_room;
  logic              viol;
  logic [2:0]        done_vec;
  int                hold_int;

  assign lamp      = {LC, LB, LA, RA, RB, RC};
  assign mon_state = state;

  // The hold check uses a signed integer compare. This keeps it well formed
  // when MAX_HOLD is 0 and no repeat is ever allowed.
  always_comb begin
    hold_int  = int'(hold_cnt);
    hold_room = (hold_int < MAX_HOLD);
  end

  // Step lookup for the nine sequence states. For each state it gives the
  // pattern being shown now and the pattern that advances it. It also gives
  // the state that advance leads to and the sequence (0 left, 1 right,
  // 2 hazard) the state belongs to. The last step advances on OFF back to
  // IDLE, and that advance is the one that completes the sequence.
  always_comb begin
    cur_pat   = PAT_OFF;
    adv_pat   = PAT_OFF;
    adv_state = S_IDLE;
    seq_id    = 2'd0;
    in_step   = 1'b1;
    case (state)
      S_L1: begin cur_pat = PAT_L1; adv_pat = PAT_L2;  adv_state = S_L2;   seq_id = 2'd0; end
      S_L2: begin cur_pat = PAT_L2; adv_pat = PAT_L3;  adv_state = S_L3;   seq_id = 2'd0; end
      S_L3: begin cur_pat = PAT_L3; adv_pat = PAT_OFF; adv_state = S_IDLE; seq_id = 2'd0; end
      S_R1: begin cur_pat = PAT_R1; adv_pat = PAT_R2;  adv_state = S_R2;   seq_id = 2'd1; end
      S_R2: begin cur_pat = PAT_R2; adv_pat = PAT_R3;  adv_state = S_R3;   seq_id = 2'd1; end
      S_R3: begin cur_pat = PAT_R3; adv_pat = PAT_OFF; adv_state = S_IDLE; seq_id = 2'd1; end
      S_H1: begin cur_pat = PAT_H1; adv_pat = PAT_H2;  adv_state = S_H2;   seq_id = 2'd2; end
      S_H2: begin cur_pat = PAT_H2; adv_pat = PAT_H3;  adv_state = S_H3;   seq_id = 2'd2; end
      S_H3: begin cur_pat = PAT_H3; adv_pat = PAT_OFF; adv_state = S_IDLE; seq_id = 2'd2; end
      default: in_step = 1'b0;
    endcase
  end

  // Next-state logic. A step state can advance, hold within the allowance,
  // or commit a violation. IDLE accepts OFF or the first step of any
  // sequence. RESYNC waits silently for OFF, and that OFF is consumed.
  // A violation on OFF returns straight to IDLE, because OFF already means
  // the bus has resynchronised. Unused codes fall back to IDLE.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    viol       = 1'b0;
    done_vec   = 3'b000;
    if (in_step) begin
      if (lamp == adv_pat) begin
        state_next = adv_state;
        hold_next  = '0;
        if (adv_pat == PAT_OFF) begin
          done_vec[seq_id] = 1'b1;
        end
      end else if ((lamp == cur_pat) && hold_room) begin
        hold_next = hold_cnt + 1'b1;
      end else begin
        viol = 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          hold_next = '0;
          case (lamp)
            PAT_OFF: state_next = S_IDLE;
            PAT_L1:  state_next = S_L1;
            PAT_R1:  state_next = S_R1;
            PAT_H1:  state_next = S_H1;
            default: viol = 1'b1;
          endcase
        end
        S_RESYNC: begin
          hold_next = '0;
          if (lamp == PAT_OFF) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
          hold_next  = '0;
        end
      endcase
    end
    if (viol) begin
      state_next = (lamp == PAT_OFF) ? S_IDLE : S_RESYNC;
      hold_next  = '0;
    end
  end

  // Registered state, pulses and counters. Reset clears everything and wins
  // over any completion or violation found in the same cycle. Counters stop
  // at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      left_done   <= 1'b0;
      right_done  <= 1'b0;
      hazard_done <= 1'b0;
      err         <= 1'b0;
      left_cnt    <= '0;
      right_cnt   <= '0;
      hazard_cnt  <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      left_done   <= done_vec[0];
      right_done  <= done_vec[1];
      hazard_done <= done_vec[2];
`ifdef STICKY_ERR_EN
      err         <= err | viol;
`else
      err         <= viol;
`endif
      if (done_vec[0] && (left_cnt != '1)) begin
        left_cnt <= left_cnt + 1'b1;
      end
      if (done_vec[1] && (right_cnt != '1)) begin
        right_cnt <= right_cnt + 1'b1;
      end
      if (done_vec[2] && (hazard_cnt != '1)) begin
        hazard_cnt <= hazard_cnt + 1'b1;
      end
      if (viol && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
